// File: rtl/pc_sequencer_if.sv
// Control-flow handshake between the LC-3 main control FSM and the PC sequencer.
// The sequencer side is the slave; the control FSM (or a bench) is the master.
interface pc_sequencer_if;
  logic        Inc;
  logic        Start;
  logic [15:0] IR;
  logic [15:0] BaseR;
  logic        BEN;
  logic [15:0] PC;
  logic        R7_we;
  logic [15:0] R7_data;
  logic        Busy;
  logic        Done;
  logic        Taken;

  modport master (
    output Inc, Start, IR, BaseR, BEN,
    input  PC, R7_we, R7_data, Busy, Done, Taken
  );

  modport slave (
    input  Inc, Start, IR, BaseR, BEN,
    output PC, R7_we, R7_data, Busy, Done, Taken
  );
endinterface

// File: rtl/pc_sequencer.sv
// LC-3 program-counter owner: fetch increment, BR/JMP/RET/JSR/JSRR sequencing
// and the R7 link write.
//
// state   | meaning
// IDLE    | accepts Start (priority) or Inc
// BR_WAIT | lets the BEN register settle
// BR_EXEC | conditional PC-relative branch on BEN
// JMP     | PC <= latched base register
// LINK    | R7 <= current PC
// JSR_TGT | PC <= PC+offset11 or latched base register
// DONE    | one-cycle completion pulse
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic         Clk,
  input logic         Reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BR_WAIT = 3'd1,
    BR_EXEC = 3'd2,
    JMP     = 3'd3,
    LINK    = 3'd4,
    JSR_TGT = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc_q, pc_nxt;
  logic [11:0] ir_q, ir_nxt;
  logic [15:0] base_q, base_nxt;
  logic        taken_q, taken_nxt;
  logic        r7_we;
  logic [15:0] off9, off11;

  assign off9  = {{7{ir_q[8]}}, ir_q[8:0]};
  assign off11 = {{5{ir_q[10]}}, ir_q[10:0]};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      base_q  <= '0;
      taken_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      ir_q    <= ir_nxt;
      base_q  <= base_nxt;
      taken_q <= taken_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ir_nxt    = ir_q;
    base_nxt  = base_q;
    taken_nxt = taken_q;
    r7_we     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          ir_nxt    = bus.IR[11:0];
          base_nxt  = bus.BaseR;
          taken_nxt = 1'b0;
          case (bus.IR[15:12])
            4'b0000: state_nxt = BR_WAIT;
            4'b1100: state_nxt = JMP;
            4'b0100: state_nxt = LINK;
            default: state_nxt = DONE;
          endcase
        end else if (bus.Inc) begin
          pc_nxt = pc_q + 16'd1;
        end
      end
      BR_WAIT: state_nxt = BR_EXEC;
      BR_EXEC: begin
        if (bus.BEN) begin
          pc_nxt    = pc_q + off9;
          taken_nxt = 1'b1;
        end
        state_nxt = DONE;
      end
      JMP: begin
        pc_nxt    = base_q;
        taken_nxt = 1'b1;
        state_nxt = DONE;
      end
      LINK: begin
        r7_we     = 1'b1;
        state_nxt = JSR_TGT;
      end
      JSR_TGT: begin
        // base_q was captured at Start, before the link write, so JSRR R7 returns to the old R7
        pc_nxt    = ir_q[11] ? (pc_q + off11) : base_q;
        taken_nxt = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.PC      = pc_q;
  assign bus.R7_we   = r7_we;
  assign bus.R7_data = r7_we ? pc_q : 16'h0000;
  assign bus.Busy    = (state != IDLE);
  assign bus.Done    = (state == DONE);
  assign bus.Taken   = taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch increment, every control-flow op,
// wrap-around, Start/Inc priority, Start while busy and reset mid-operation.
module tb_pc_sequencer;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_fail;
  int   done_cyc;
  logic        r7we_c1;
  logic [15:0] r7data_c1;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(16'h3000)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Issue one op; returns at the Done cycle (or after the cycle budget).
  task automatic do_op(input logic [15:0] ir, input logic [15:0] base,
                       input logic [15:0] base_after, input logic ben, input logic inc);
    bus.IR    = ir;
    bus.BaseR = base;
    bus.BEN   = ben;
    bus.Inc   = inc;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    bus.Inc   = 1'b0;
    bus.BaseR = base_after;
    done_cyc  = -1;
    r7we_c1   = 1'b0;
    r7data_c1 = 16'h0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 1) begin
        r7we_c1   = bus.R7_we;
        r7data_c1 = bus.R7_data;
      end
      if (bus.Done) begin
        done_cyc = c;
        break;
      end
      step();
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    bus.Inc   = 1'b0;
    bus.Start = 1'b0;
    bus.IR    = 16'h0;
    bus.BaseR = 16'h0;
    bus.BEN   = 1'b0;
    Reset     = 1'b1;
    step();
    step();
    Reset = 1'b0;
    check_val("rst_pc", bus.PC, 16'h3000);
    check_val("rst_busy", bus.Busy, 0);
    check_val("rst_done", bus.Done, 0);
    check_val("rst_taken", bus.Taken, 0);
    check_val("rst_r7we", bus.R7_we, 0);
    check_val("rst_r7data", bus.R7_data, 0);

    bus.Inc = 1'b1;
    step(); check_val("inc1_pc", bus.PC, 16'h3001); check_val("inc1_busy", bus.Busy, 0);
    step(); check_val("inc2_pc", bus.PC, 16'h3002); check_val("inc2_busy", bus.Busy, 0);
    step(); check_val("inc3_pc", bus.PC, 16'h3003); check_val("inc3_busy", bus.Busy, 0);
    bus.Inc = 1'b0;
    step();
    check_val("inc_stop_pc", bus.PC, 16'h3003);

    // JMP R2 to set PC = 0x3010
    do_op(16'hC080, 16'h3010, 16'h0, 1'b0, 1'b0);
    check_val("jmp_done_cyc", done_cyc, 2);
    check_val("jmp_pc", bus.PC, 16'h3010);
    check_val("jmp_taken", bus.Taken, 1);
    step();

    do_op(16'h0E05, 16'h0, 16'h0, 1'b1, 1'b0);
    check_val("br_t_done_cyc", done_cyc, 3);
    check_val("br_t_pc", bus.PC, 16'h3015);
    check_val("br_t_taken", bus.Taken, 1);
    check_val("br_t_busy", bus.Busy, 1);
    step();
    check_val("br_t_taken_held", bus.Taken, 1);
    check_val("br_t_idle", bus.Busy, 0);

    do_op(16'hC080, 16'h3010, 16'h0, 1'b0, 1'b0);
    step();
    do_op(16'h0E05, 16'h0, 16'h0, 1'b0, 1'b0);
    check_val("br_nt_done_cyc", done_cyc, 3);
    check_val("br_nt_pc", bus.PC, 16'h3010);
    check_val("br_nt_taken", bus.Taken, 0);
    step();

    do_op(16'h0FFF, 16'h0, 16'h0, 1'b1, 1'b0);
    check_val("br_neg_pc", bus.PC, 16'h300F);
    step();

    do_op(16'hC080, 16'hFFFF, 16'h0, 1'b0, 1'b0);
    step();
    check_val("wrap_pre_pc", bus.PC, 16'hFFFF);
    bus.Inc = 1'b1;
    step();
    bus.Inc = 1'b0;
    check_val("wrap_pc", bus.PC, 16'h0000);

    do_op(16'hC080, 16'h4000, 16'h0, 1'b0, 1'b0);
    step();
    do_op(16'h4802, 16'h0, 16'h0, 1'b0, 1'b0);
    check_val("jsr_r7we_c1", r7we_c1, 1);
    check_val("jsr_r7data_c1", r7data_c1, 16'h4000);
    check_val("jsr_done_cyc", done_cyc, 3);
    check_val("jsr_pc", bus.PC, 16'h4002);
    check_val("jsr_taken", bus.Taken, 1);
    check_val("jsr_r7we_done", bus.R7_we, 0);
    check_val("jsr_r7data_done", bus.R7_data, 0);
    step();

    do_op(16'h4080, 16'h5000, 16'h1234, 1'b0, 1'b0);
    check_val("jsrr_r7we_c1", r7we_c1, 1);
    check_val("jsrr_r7data_c1", r7data_c1, 16'h4002);
    check_val("jsrr_done_cyc", done_cyc, 3);
    check_val("jsrr_pc", bus.PC, 16'h5000);
    step();

    do_op(16'hC1C0, 16'h3456, 16'h3456, 1'b0, 1'b0);
    check_val("ret_done_cyc", done_cyc, 2);
    check_val("ret_pc", bus.PC, 16'h3456);
    check_val("ret_r7we_c1", r7we_c1, 0);
    step();

    do_op(16'h1000, 16'h0, 16'h0, 1'b0, 1'b0);
    check_val("add_done_cyc", done_cyc, 1);
    check_val("add_pc", bus.PC, 16'h3456);
    check_val("add_taken", bus.Taken, 0);
    step();

    // Start and Inc together: Inc must be dropped
    do_op(16'h1000, 16'h0, 16'h0, 1'b0, 1'b1);
    check_val("prio_done_cyc", done_cyc, 1);
    check_val("prio_pc", bus.PC, 16'h3456);
    step();
    check_val("prio_pc_idle", bus.PC, 16'h3456);

    // Start while busy must be ignored
    bus.IR    = 16'h0E05;
    bus.BEN   = 1'b0;
    bus.Start = 1'b1;
    step();
    bus.IR    = 16'hC080;
    bus.BaseR = 16'h7777;
    step();
    step();
    bus.Start = 1'b0;
    check_val("busy_start_done", bus.Done, 1);
    check_val("busy_start_pc", bus.PC, 16'h3456);
    check_val("busy_start_taken", bus.Taken, 0);
    step();
    check_val("busy_start_idle", bus.Busy, 0);
    check_val("busy_start_pc_idle", bus.PC, 16'h3456);

    // Reset asserted while in BR_EXEC
    bus.IR    = 16'h0E05;
    bus.BEN   = 1'b1;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    step();
    check_val("abort_in_exec", bus.Busy, 1);
    Reset = 1'b1;
    step();
    check_val("abort_pc", bus.PC, 16'h3000);
    check_val("abort_busy", bus.Busy, 0);
    check_val("abort_done", bus.Done, 0);
    check_val("abort_taken", bus.Taken, 0);
    Reset = 1'b0;
    step();
    check_val("abort_done_after", bus.Done, 0);
    check_val("abort_r7we_after", bus.R7_we, 0);
    check_val("abort_pc_after", bus.PC, 16'h3000);
    step();
    check_val("abort_busy_after", bus.Busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
